// File: rtl/operand_stack_unit.sv
// Operand stack for the stack processor.
// Feeds TOS/NOS to the ALU and takes ALU results back.
module operand_stack_unit #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH_LOG2   = 4,
    parameter int ADDR_WIDTH   = 12,
    parameter int RESULT_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              CMD,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [DATA_WIDTH-1:0]   PUSH_DATA,
    input  logic [RESULT_WIDTH-1:0] RESULT_IN,
    input  logic                    CLR_ERR,
    output logic [DATA_WIDTH-1:0]   TOP_DATA,
    output logic [DATA_WIDTH-1:0]   NEXT_DATA,
    output logic [ADDR_WIDTH-1:0]   TOS_PTR,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic                    ERR_OVERFLOW,
    output logic                    ERR_UNDERFLOW
);
    localparam int AW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] C_PUSH     = 3'b001;
    localparam logic [2:0] C_POP      = 3'b010;
    localparam logic [2:0] C_DUP      = 3'b011;
    localparam logic [2:0] C_SWAP     = 3'b100;
    localparam logic [2:0] C_BINOP    = 3'b101;
    localparam logic [2:0] C_PUSH_ALU = 3'b110;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic                  rdy_q;
    logic                  swap_q, swap_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] top_q, top_d;
    logic [DATA_WIDTH-1:0] next_q, next_d;
    logic                  ovf_q, unf_q;
    logic                  ovf_set, unf_set;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  we_a, we_b;
    logic [AW-1:0]         wa_a, wa_b;
    logic [DATA_WIDTH-1:0] wd_a, wd_b;

    logic                  accept;
    logic                  is_full, is_empty, lt2;
    logic [CW-1:0]         n_m1, n_m2, n_m3;
    logic [DATA_WIDTH-1:0] third;
    logic [DATA_WIDTH-1:0] res_lo, push_val;
    logic                  unused_res;

    assign unused_res = ^RESULT_IN[RESULT_WIDTH-1:DATA_WIDTH];
    assign res_lo     = RESULT_IN[DATA_WIDTH-1:0];

    assign CMD_READY = rdy_q & (state_q == IDLE);
    assign accept    = CMD_VALID & CMD_READY;
    assign is_full   = (cnt_q == DEPTH_C);
    assign is_empty  = (cnt_q == '0);
    assign lt2       = (cnt_q < CW'(2));
    assign n_m1      = cnt_q - CW'(1);
    assign n_m2      = cnt_q - CW'(2);
    assign n_m3      = cnt_q - CW'(3);
    // Entry that becomes NOS after the stack shrinks by one.
    assign third     = (cnt_q >= CW'(3)) ? mem[n_m3[AW-1:0]] : '0;
    assign push_val  = (CMD == C_PUSH) ? PUSH_DATA : res_lo;

    assign TOP_DATA      = top_q;
    assign NEXT_DATA     = next_q;
    assign TOS_PTR       = {{(ADDR_WIDTH-CW){1'b0}}, cnt_q};
    assign EMPTY         = is_empty;
    assign FULL          = is_full;
    assign ERR_OVERFLOW  = ovf_q;
    assign ERR_UNDERFLOW = unf_q;

    // Next-state, stack update and memory write decode.
    always_comb begin
        state_d = state_q;
        swap_d  = swap_q;
        cnt_d   = cnt_q;
        top_d   = top_q;
        next_d  = next_q;
        we_a    = 1'b0;
        wa_a    = cnt_q[AW-1:0];
        wd_a    = top_q;
        we_b    = 1'b0;
        wa_b    = n_m2[AW-1:0];
        wd_b    = top_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (state_q == BUSY) begin
            state_d = IDLE;
            if (swap_q) begin
                we_a   = 1'b1;
                wa_a   = n_m1[AW-1:0];
                wd_a   = next_q;
                we_b   = 1'b1;
                top_d  = next_q;
                next_d = top_q;
            end else begin
                we_a   = 1'b1;
                wa_a   = n_m2[AW-1:0];
                wd_a   = res_lo;
                top_d  = res_lo;
                next_d = third;
                cnt_d  = n_m1;
            end
        end else if (accept) begin
            case (CMD)
                C_PUSH, C_PUSH_ALU: begin
                    if (is_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        we_a   = 1'b1;
                        wd_a   = push_val;
                        top_d  = push_val;
                        next_d = top_q;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
                C_POP: begin
                    if (is_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        top_d  = next_q;
                        next_d = third;
                        cnt_d  = n_m1;
                    end
                end
                C_DUP: begin
                    if (is_full) begin
                        ovf_set = 1'b1;
                    end else if (is_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        we_a   = 1'b1;
                        next_d = top_q;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
                C_SWAP, C_BINOP: begin
                    if (lt2) begin
                        unf_set = 1'b1;
                    end else begin
                        state_d = BUSY;
                        swap_d  = (CMD == C_SWAP);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state, cached top/next, count and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            swap_q  <= 1'b0;
            cnt_q   <= '0;
            top_q   <= '0;
            next_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            swap_q  <= swap_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
            next_q  <= next_d;
            ovf_q   <= ovf_set | (ovf_q & ~CLR_ERR);
            unf_q   <= unf_set | (unf_q & ~CLR_ERR);
        end
    end

    // Stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we_a) mem[wa_a] <= wd_a;
        if (we_b) mem[wa_b] <= wd_b;
    end
endmodule
